// File: rtl/deadlock_pkg.sv
// Shared types and helpers for the per-process deadlock detectors.
package deadlock_pkg;

  localparam int unsigned MAX_PROC = 32;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_STALL  = 3'd1,
    ST_DETECT = 3'd2,
    ST_WAIT   = 3'd3,
    ST_TOKEN  = 3'd4
  } dl_state_e;

  // Isolates the lowest set bit (two's-complement trick); zero in, zero out.
  function automatic logic [MAX_PROC-1:0] lowest_onehot(input logic [MAX_PROC-1:0] vec);
    lowest_onehot = vec & (~vec + MAX_PROC'(1));
  endfunction

endpackage

// File: rtl/deadlock_detect_unit_stall_counter.sv
// Saturating stall-duration counter; hit_c flags the detection threshold.
module dl_stall_counter #(
  parameter int unsigned BLOCK_THRESHOLD = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic hit_c
);

  localparam int unsigned CNT_W = $clog2(BLOCK_THRESHOLD + 1);

  logic [CNT_W-1:0] count;

  assign hit_c = (count == CNT_W'(BLOCK_THRESHOLD));

  // Holds at the threshold rather than wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !hit_c) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/deadlock_detect_unit.sv
// Per-process deadlock detector: stall timing, detect flag and token forwarding
// for dependence-cycle tracing by the report unit.
module deadlock_detect_unit
  import deadlock_pkg::*;
#(
  parameter int unsigned PROC_NUM        = 4,
  parameter int unsigned MY_ID           = 0,
  parameter int unsigned BLOCK_THRESHOLD = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                proc_blocked,
  input  logic [PROC_NUM-1:0] dep_vec,
  input  logic [PROC_NUM-1:0] blocked_vec,
  input  logic                dl_detect_in,
  input  logic [PROC_NUM-1:0] origin,
  input  logic                token_clear,
  input  logic                token_in,
  output logic                dl_out,
  output logic [PROC_NUM-1:0] token_out_vec
);

  dl_state_e           state, state_nxt;
  logic                is_origin, is_origin_nxt;
  logic                dl_out_nxt;
  logic [PROC_NUM-1:0] token_out_nxt;
  logic [PROC_NUM-1:0] self_mask;
  logic [PROC_NUM-1:0] eff_dep_c;
  logic [PROC_NUM-1:0] first_dep_c;
  logic                stall_ok_c;
  logic                origin_mine_c;
  logic                cnt_clear;
  logic                cnt_inc;
  logic                hit_c;

  assign self_mask     = PROC_NUM'(1) << MY_ID;
  assign eff_dep_c     = dep_vec & ~self_mask;
  assign first_dep_c   = PROC_NUM'(lowest_onehot(MAX_PROC'(eff_dep_c)));
  assign origin_mine_c = |(origin & self_mask);

  // Stalled only if every process we wait on is itself stalled.
  assign stall_ok_c = proc_blocked && (eff_dep_c != '0) &&
                      ((eff_dep_c & ~blocked_vec) == '0);

  dl_stall_counter #(
    .BLOCK_THRESHOLD(BLOCK_THRESHOLD)
  ) u_stall_counter (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .hit_c (hit_c)
  );

  always_comb begin
    state_nxt     = state;
    is_origin_nxt = is_origin;
    dl_out_nxt    = 1'b0;
    token_out_nxt = '0;
    cnt_clear     = 1'b1;
    cnt_inc       = 1'b0;

    case (state)
      ST_RUN: begin
        if (dl_detect_in) begin
          state_nxt = ST_WAIT;
        end else if (stall_ok_c) begin
          state_nxt = ST_STALL;
          cnt_clear = 1'b0;
          cnt_inc   = 1'b1;
        end
      end

      ST_STALL: begin
        if (dl_detect_in) begin
          state_nxt = ST_WAIT;
        end else if (!stall_ok_c) begin
          state_nxt = ST_RUN;
        end else if (hit_c) begin
          state_nxt  = ST_DETECT;
          dl_out_nxt = 1'b1;
        end else begin
          cnt_clear = 1'b0;
          cnt_inc   = 1'b1;
        end
      end

      ST_DETECT: begin
        if (dl_detect_in) begin
          state_nxt = ST_WAIT;
        end else begin
          dl_out_nxt = 1'b1;
        end
      end

      // Priority: clear, then origin (drops a coincident token), then token.
      ST_WAIT: begin
        if (token_clear) begin
          state_nxt = ST_WAIT;
        end else if (origin_mine_c) begin
          state_nxt     = ST_TOKEN;
          is_origin_nxt = 1'b1;
          token_out_nxt = first_dep_c;
        end else if (token_in) begin
          state_nxt     = ST_TOKEN;
          dl_out_nxt    = 1'b1;
          token_out_nxt = first_dep_c;
        end
      end

      ST_TOKEN: begin
        state_nxt = ST_WAIT;
      end

      default: begin
        state_nxt = ST_RUN;
      end
    endcase

    if (token_clear) begin
      is_origin_nxt = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_RUN;
      is_origin     <= 1'b0;
      dl_out        <= 1'b0;
      token_out_vec <= '0;
    end else begin
      state         <= state_nxt;
      is_origin     <= is_origin_nxt;
      dl_out        <= dl_out_nxt;
      token_out_vec <= token_out_nxt;
    end
  end

endmodule

// File: tb/tb_deadlock_detect_unit.sv
// Vector-table bench for deadlock_detect_unit: two instances (MY_ID 0 and 1), PROC_NUM 2, threshold 4.
module tb_deadlock_detect_unit;

  localparam int unsigned P  = 2;
  localparam int unsigned TH = 4;

  typedef struct {
    bit         inst;
    bit         rst;
    bit         pb;
    logic [1:0] dep;
    logic [1:0] blk;
    bit         ddi;
    logic [1:0] org;
    bit         clr;
    bit         tin;
    bit         edl;
    logic [1:0] etok;
  } vec_t;

  typedef struct {
    bit         inst;
    int         idx;
    bit         edl;
    logic [1:0] etok;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         pb   [2];
  logic [P-1:0] dep  [2];
  logic [P-1:0] blk  [2];
  logic         ddi  [2];
  logic [P-1:0] org  [2];
  logic         clr  [2];
  logic         tin  [2];
  logic         dl_w [2];
  logic [P-1:0] tok_w[2];

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  deadlock_detect_unit #(.PROC_NUM(P), .MY_ID(0), .BLOCK_THRESHOLD(TH)) u0 (
    .clock(clock), .reset(reset), .proc_blocked(pb[0]), .dep_vec(dep[0]),
    .blocked_vec(blk[0]), .dl_detect_in(ddi[0]), .origin(org[0]),
    .token_clear(clr[0]), .token_in(tin[0]), .dl_out(dl_w[0]), .token_out_vec(tok_w[0])
  );

  deadlock_detect_unit #(.PROC_NUM(P), .MY_ID(1), .BLOCK_THRESHOLD(TH)) u1 (
    .clock(clock), .reset(reset), .proc_blocked(pb[1]), .dep_vec(dep[1]),
    .blocked_vec(blk[1]), .dl_detect_in(ddi[1]), .origin(org[1]),
    .token_clear(clr[1]), .token_in(tin[1]), .dl_out(dl_w[1]), .token_out_vec(tok_w[1])
  );

  function automatic void add(bit inst, bit rst, bit p, logic [1:0] d, logic [1:0] b, bit dd,
                              logic [1:0] o, bit c, bit t, bit edl, logic [1:0] etok);
    vec_t v;
    v.inst = inst; v.rst = rst; v.pb = p; v.dep = d; v.blk = b; v.ddi = dd;
    v.org = o; v.clr = c; v.tin = t; v.edl = edl; v.etok = etok;
    vecs.push_back(v);
  endfunction

  task automatic drive(input vec_t v);
    reset = v.rst;
    for (int k = 0; k < 2; k++) begin
      if (k == int'(v.inst)) begin
        pb[k] = v.pb; dep[k] = v.dep; blk[k] = v.blk; ddi[k] = v.ddi;
        org[k] = v.org; clr[k] = v.clr; tin[k] = v.tin;
      end else begin
        pb[k] = 1'b0; dep[k] = '0; blk[k] = '0; ddi[k] = 1'b0;
        org[k] = '0; clr[k] = 1'b0; tin[k] = 1'b0;
      end
    end
  endtask

  initial begin
    exp_t e;
    vec_t s;
    int   cycles;

    // Instance 0: reset, detection latency and hold
    add(0, 1, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 2'b00);
    for (int i = 0; i < 4; i++) add(0, 0, 1, 2'b10, 2'b11, 0, 2'b00, 0, 0, 0, 2'b00);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 2'b10, 2'b11, 0, 2'b00, 0, 0, 1, 2'b00);
    add(0, 0, 1, 2'b10, 2'b11, 1, 2'b00, 0, 0, 0, 2'b00);
    // Origin start, then returning token
    add(0, 0, 0, 2'b10, 2'b00, 0, 2'b01, 0, 0, 0, 2'b10);
    add(0, 0, 0, 2'b10, 2'b00, 0, 2'b00, 0, 0, 0, 2'b00);
    add(0, 0, 0, 2'b10, 2'b00, 0, 2'b00, 0, 0, 0, 2'b00);
    add(0, 0, 0, 2'b10, 2'b00, 0, 2'b00, 0, 1, 1, 2'b10);
    add(0, 0, 0, 2'b10, 2'b00, 0, 2'b00, 0, 0, 0, 2'b00);
    // Clear beats token; origin beats token; dead-end token; foreign origin bit
    add(0, 0, 0, 2'b10, 2'b00, 0, 2'b00, 1, 1, 0, 2'b00);
    add(0, 0, 0, 2'b10, 2'b00, 0, 2'b00, 0, 0, 0, 2'b00);
    add(0, 0, 0, 2'b10, 2'b00, 0, 2'b01, 0, 1, 0, 2'b10);
    add(0, 0, 0, 2'b10, 2'b00, 0, 2'b00, 0, 0, 0, 2'b00);
    add(0, 0, 0, 2'b10, 2'b00, 0, 2'b00, 0, 1, 1, 2'b10);
    add(0, 0, 0, 2'b10, 2'b00, 0, 2'b00, 0, 0, 0, 2'b00);
    add(0, 0, 0, 2'b01, 2'b00, 0, 2'b00, 0, 1, 1, 2'b00);
    add(0, 0, 0, 2'b10, 2'b00, 0, 2'b10, 0, 0, 0, 2'b00);
    // Reset while in ST_TOKEN
    add(0, 0, 0, 2'b10, 2'b00, 0, 2'b00, 0, 1, 1, 2'b10);
    add(0, 1, 0, 2'b10, 2'b00, 0, 2'b00, 0, 0, 0, 2'b00);
    // Stall broken for one cycle restarts the count
    for (int i = 0; i < 3; i++) add(0, 0, 1, 2'b10, 2'b11, 0, 2'b00, 0, 0, 0, 2'b00);
    add(0, 0, 1, 2'b10, 2'b01, 0, 2'b00, 0, 0, 0, 2'b00);
    for (int i = 0; i < 4; i++) add(0, 0, 1, 2'b10, 2'b11, 0, 2'b00, 0, 0, 0, 2'b00);
    add(0, 0, 1, 2'b10, 2'b11, 0, 2'b00, 0, 0, 1, 2'b00);
    // Global detect seen in ST_RUN freezes detection
    add(0, 1, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 2'b00);
    add(0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 0, 0, 0, 2'b00);
    for (int i = 0; i < 6; i++) add(0, 0, 1, 2'b10, 2'b11, 0, 2'b00, 0, 0, 0, 2'b00);
    add(0, 0, 0, 2'b10, 2'b00, 0, 2'b00, 0, 1, 1, 2'b10);
    add(0, 0, 0, 2'b10, 2'b00, 0, 2'b00, 0, 0, 0, 2'b00);
    // Instance 1: non-origin hop
    add(1, 1, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 2'b00);
    add(1, 0, 0, 2'b01, 2'b00, 1, 2'b00, 0, 0, 0, 2'b00);
    add(1, 0, 0, 2'b01, 2'b00, 0, 2'b00, 0, 1, 1, 2'b01);
    add(1, 0, 0, 2'b01, 2'b00, 0, 2'b00, 0, 0, 0, 2'b00);
    add(1, 0, 0, 2'b01, 2'b00, 0, 2'b01, 0, 0, 0, 2'b00);
    add(1, 0, 0, 2'b01, 2'b00, 0, 2'b10, 0, 0, 0, 2'b01);
    add(1, 0, 0, 2'b01, 2'b00, 0, 2'b00, 0, 0, 0, 2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      e.inst = vecs[i].inst; e.idx = i; e.edl = vecs[i].edl; e.etok = vecs[i].etok;
      sb.push_back(e);
      @(posedge clock);
      #1;
      e = sb.pop_front();
      n_vec++;
      if (dl_w[e.inst] !== e.edl) begin
        n_err++;
        $display("FAIL vec%0d u%0d dl_out got %b expected %b", e.idx, e.inst, dl_w[e.inst], e.edl);
      end
      if (tok_w[e.inst] !== e.etok) begin
        n_err++;
        $display("FAIL vec%0d u%0d token_out_vec got %b expected %b", e.idx, e.inst, tok_w[e.inst], e.etok);
      end
    end

    // Hand sequence: measure detection latency with a bounded wait
    s.inst = 0; s.rst = 1; s.pb = 0; s.dep = 2'b00; s.blk = 2'b00; s.ddi = 0;
    s.org = 2'b00; s.clr = 0; s.tin = 0; s.edl = 0; s.etok = 2'b00;
    drive(s);
    @(posedge clock);
    #1;
    s.rst = 0; s.pb = 1; s.dep = 2'b10; s.blk = 2'b11;
    drive(s);
    cycles = 0;
    while (cycles <= 20) begin
      @(posedge clock);
      #1;
      cycles++;
      if (dl_w[0] === 1'b1) break;
    end
    n_vec++;
    if (cycles != int'(TH) + 1) begin
      n_err++;
      $display("FAIL detect_latency got %0d cycles expected %0d", cycles, TH + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
